// File: rtl/uart_transmitter.sv
// uart_transmitter: serial transmit side of the UART.
// Frame: start bit, 8 data bits LSB-first, optional even parity bit, one stop bit.
// Every bit is held for exactly CLOCKS_PER_BIT cycles of clk.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and its register).
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | start bit, tx=0
// DATA   | data bits, tx=shift[0], bit_cnt 0..7
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit, tx=1, returns to IDLE at bit end
module uart_transmitter #(
    parameter int CLOCKS_PER_BIT = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [2:0]    state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] baud_cnt;
    logic          tx_r;
    logic          accept;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_r;
`endif

    assign accept   = tx_valid && (state == S_IDLE);
    assign bit_end  = (state != S_IDLE) && (baud_cnt == BIT_LAST);
    assign tx_ready = (state == S_IDLE);
    assign tx_busy  = (state != S_IDLE);
    assign tx       = tx_r;

    // Baud counter: held at 0 in IDLE, counts each clock of a frame, wraps at bit end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (state == S_IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Frame sequencer; tx is registered so it only moves on bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            tx_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx_r <= 1'b1;
                    if (accept) begin
                        shift    <= tx_data;
                        tx_r     <= 1'b0;
                        state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_r <= ^tx_data;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state <= S_DATA;
                        tx_r  <= shift[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
                            tx_r    <= parity_r;
`else
                            state   <= S_STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_r    <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state <= S_STOP;
                        tx_r  <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state <= S_IDLE;
                        tx_r  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed bench for uart_transmitter.
// Main instance runs CLOCKS_PER_BIT=8; a second instance runs CLOCKS_PER_BIT=5.
// Honours UART_TX_PARITY_EN for expected frame layout.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx;
    logic [7:0] data5 = 8'h00;
    logic       valid5 = 1'b0;
    logic       ready5, busy5, tx5;

    int vectors = 0;
    int errors  = 0;

    uart_transmitter #(.CLOCKS_PER_BIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx(tx)
    );

    uart_transmitter #(.CLOCKS_PER_BIT(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .tx_data(data5), .tx_valid(valid5),
        .tx_ready(ready5), .tx_busy(busy5), .tx(tx5)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        b[9] = ^d;
`endif
        return b;
    endfunction

    task automatic start_frame(input logic [7:0] d, input bit hold_valid);
        @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept: tx_ready=%b expected 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) tx_valid = 1'b0;
        vectors++;
        if (tx !== 1'b0 || tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_edge: tx=%b ready=%b busy=%b expected 0 0 1", tx, tx_ready, tx_busy);
        end
    endtask

    // Called just after the accept edge; checks every cycle of every bit.
    task automatic check_bits(input logic [7:0] d, input bit chg);
        logic [10:0] exp;
        logic bad, got;
        exp = frame_bits(d);
        for (int i = 0; i < NB; i++) begin
            bad = 1'b0;
            got = exp[i];
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (chg && i == 0 && c == 0) tx_data = 8'hFF;
                if (tx !== exp[i]) begin
                    bad = 1'b1;
                    got = tx;
                end
            end
            vectors++;
            if (bad) begin
                errors++;
                $display("FAIL frame_%02h bit %0d: tx=%b expected %b in all 8 clocks", d, i, got, exp[i]);
            end
        end
        vectors++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_last_cycle: tx_ready=%b expected 0", tx_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_%0d: ready=%b busy=%b tx=%b expected 1 0 1", NB * 8, tx_ready, tx_busy, tx);
        end
    endtask

    task automatic test_reset();
        logic toggled;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%b ready=%b busy=%b expected 1 1 0", tx, tx_ready, tx_busy);
        end
        rst_n = 1'b1;
        toggled = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx5 !== 1'b1) toggled = 1'b1;
        end
        vectors++;
        if (toggled) begin
            errors++;
            $display("FAIL idle_quiet: tx toggled=%b expected 0", toggled);
        end
    endtask

    task automatic test_single_byte();
        start_frame(8'hA5, 1'b0);
        check_bits(8'hA5, 1'b0);
    endtask

    task automatic test_data_change();
        start_frame(8'h07, 1'b0);
        check_bits(8'h07, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_frame(8'h00, 1'b1);
        tx_data = 8'hFF;
        check_bits(8'h00, 1'b0);
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: tx=%b ready=%b expected 1 1", tx, tx_ready);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        vectors++;
        if (tx !== 1'b0 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_start: tx=%b ready=%b expected 0 0", tx, tx_ready);
        end
        check_bits(8'hFF, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'h55, 1'b0);
        repeat (36) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_data_bit3: tx=%b expected 0", tx);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx=%b ready=%b busy=%b expected 1 1 0", tx, tx_ready, tx_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_frame(8'h3C, 1'b0);
        check_bits(8'h3C, 1'b0);
    endtask

    task automatic test_wrap();
        logic [10:0] exp;
        logic bad, got;
        int maxb;
        exp = frame_bits(8'h96);
        maxb = 0;
        @(negedge clk);
        data5  = 8'h96;
        valid5 = 1'b1;
        @(posedge clk);
        #1;
        valid5 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bad = 1'b0;
            got = exp[i];
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (int'(dut5.baud_cnt) > maxb) maxb = int'(dut5.baud_cnt);
                if (tx5 !== exp[i]) begin
                    bad = 1'b1;
                    got = tx5;
                end
            end
            vectors++;
            if (bad) begin
                errors++;
                $display("FAIL wrap5 bit %0d: tx=%b expected %b in all 5 clocks", i, got, exp[i]);
            end
        end
        vectors++;
        if (ready5 !== 1'b0) begin
            errors++;
            $display("FAIL wrap5_ready_early: ready=%b expected 0", ready5);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ready5 !== 1'b1) begin
            errors++;
            $display("FAIL wrap5_ready: ready=%b expected 1", ready5);
        end
        vectors++;
        if (maxb != 4) begin
            errors++;
            $display("FAIL wrap5_baud_max: max=%0d expected 4", maxb);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_data_change();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
